// File: rtl/lsu_pkg.sv
// Shared load/store definitions: funct3 encodings, FSM states and request checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_MERGE_WR = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

  // funct3[1:0] carries the access size for both signed and unsigned loads.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic is_legal_f3(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: load extract/extend and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none, outputs follow inputs.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_data
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_ins;

  assign sh      = {off, 3'b000};
  assign shifted = rdata >> sh;

  always_comb begin
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    lane_mask   = 32'h0;
    lane_ins    = 32'h0;
    merged_data = wdata;
    case (funct3)
      F3_B: begin
        lane_mask   = 32'h0000_00FF << sh;
        lane_ins    = {24'h0, wdata[7:0]} << sh;
        merged_data = (old_word & ~lane_mask) | lane_ins;
      end
      F3_H: begin
        lane_mask   = 32'h0000_FFFF << sh;
        lane_ins    = {16'h0, wdata[15:0]} << sh;
        merged_data = (old_word & ~lane_mask) | lane_ins;
      end
      default: merged_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store requester driving a word-addressed async-read/sync-write memory.
// Latency: accept to response 2 cycles (loads, SW, errors), 3 cycles (SB/SH read-modify-write).
// Backpressure: o_req_ready only in IDLE; requester holds i_req_* until accepted.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_wrenb,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_err,
  output logic [31:0]       o_rdata
);

  state_t              state;
  logic                cmd_we;
  logic [2:0]          cmd_f3;
  logic [1:0]          cmd_off;
  logic [31:0]         cmd_wdata;
  logic [31:0]         merge_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                req_legal;
  logic [31:0]         load_data;
  logic [31:0]         merged_data;
  logic                addr_hi_unused;

  // Upper byte-address bits alias onto the memory; they are deliberately dropped.
  assign addr_hi_unused = ^i_addr[31:ADDR_W+2];

  assign o_req_ready = (state == ST_IDLE);
  assign req_legal   = is_legal_f3(i_req_we, i_funct3) && !is_misaligned(i_funct3, i_addr[1:0]);
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wrenb = ((state == ST_ACCESS) && cmd_we && (cmd_f3 == F3_W)) ||
                       (state == ST_MERGE_WR);
  assign o_mem_wdata = (state == ST_MERGE_WR) ? merged_data : cmd_wdata;

  lsu_lane_align u_lane_align (
    .rdata       (i_mem_rdata),
    .off         (cmd_off),
    .funct3      (cmd_f3),
    .old_word    (merge_q),
    .wdata       (cmd_wdata),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      cmd_we      <= 1'b0;
      cmd_f3      <= 3'b000;
      cmd_off     <= 2'b00;
      cmd_wdata   <= 32'h0;
      merge_q     <= 32'h0;
      mem_addr_q  <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rdata     <= 32'h0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req_valid) begin
            cmd_we    <= i_req_we;
            cmd_f3    <= i_funct3;
            cmd_off   <= i_addr[1:0];
            cmd_wdata <= i_wdata;
            // Rejected requests leave the memory address untouched.
            if (req_legal) begin
              mem_addr_q <= i_addr[ADDR_W+1:2];
              state      <= ST_ACCESS;
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_ACCESS: begin
          if (!cmd_we) begin
            o_rdata     <= load_data;
            o_rsp_valid <= 1'b1;
            state       <= ST_IDLE;
          end else if (cmd_f3 == F3_W) begin
            o_rsp_valid <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            merge_q <= i_mem_rdata;
            state   <= ST_MERGE_WR;
          end
        end
        ST_MERGE_WR: begin
          o_rsp_valid <= 1'b1;
          state       <= ST_IDLE;
        end
        ST_ERR: begin
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b1;
          o_rdata     <= 32'h0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: behavioural memory, table of load/error vectors,
// scoreboard of expected responses, hand sequences for stores and mid-RMW reset.
module tb_lsu_mem_ctrl;

  localparam int ADDR_W = 10;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [2:0]        i_funct3;
  logic [31:0]       i_addr;
  logic [31:0]       i_wdata;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic              o_mem_wrenb;
  logic [31:0]       i_mem_rdata;
  logic              o_rsp_valid;
  logic              o_rsp_err;
  logic [31:0]       o_rdata;

  lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wrenb (o_mem_wrenb),
    .i_mem_rdata (i_mem_rdata),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_err   (o_rsp_err),
    .o_rdata     (o_rdata)
  );

  // Memory model: async read, sync write; bench preloads go through the same port.
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              tb_we;
  logic [ADDR_W-1:0] tb_waddr;
  logic [31:0]       tb_wdat;

  assign i_mem_rdata = mem[o_mem_addr];

  always @(posedge i_clk) begin
    if (o_mem_wrenb) mem[o_mem_addr] <= o_mem_wdata;
    else if (tb_we) mem[tb_waddr] <= tb_wdat;
  end

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  vec_t        vt[15];
  int          n_chk;
  int          n_err;
  int          n_wr;
  int          cyc;
  logic [31:0] model_rdata;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_mem_wrenb) n_wr++;
    if (i_rst_n && o_rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_err", {31'h0, o_rsp_err}, {31'h0, mon_e.err});
        chk("rsp_rdata", o_rdata, mon_e.rd);
        chk("rsp_latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  task automatic poke(input int a, input logic [31:0] d);
    tb_we    = 1'b1;
    tb_waddr = a[ADDR_W-1:0];
    tb_wdat  = d;
    @(posedge i_clk); #1;
    tb_we    = 1'b0;
  endtask

  // Drives one request, waits for acceptance, queues its expected response.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic err, input logic [31:0] rd,
                       input int lat, input bit track, output int acc);
    exp_t e;
    int   guard;
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_funct3    = f3;
    i_addr      = addr;
    i_wdata     = wd;
    guard       = 0;
    while (!o_req_ready && guard < 50) begin
      @(posedge i_clk); #1;
      guard++;
    end
    chk("req_accept", {31'h0, o_req_ready}, 32'h1);
    acc = cyc;
    if (!we || err) model_rdata = err ? 32'h0 : rd;
    e.err = err;
    e.rd  = model_rdata;
    e.lat = lat;
    e.acc = acc;
    if (track) sb_q.push_back(e);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      @(posedge i_clk); #1;
      guard++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'h0, o_req_ready}, 32'h1);
    chk({tag, "_rsp_valid"}, {31'h0, o_rsp_valid}, 32'h0);
    chk({tag, "_rsp_err"}, {31'h0, o_rsp_err}, 32'h0);
    chk({tag, "_rdata"}, o_rdata, 32'h0);
    chk({tag, "_mem_addr"}, {22'h0, o_mem_addr}, 32'h0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 32'h0);
    chk({tag, "_wrenb"}, {31'h0, o_mem_wrenb}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a1;
    int a2;
    int wr_snap;

    vt[0]  = '{1'b0, 3'b000, 32'h0000_0014, 32'h0,         1'b0, 32'hFFFF_FFF0};
    vt[1]  = '{1'b0, 3'b100, 32'h0000_0015, 32'h0,         1'b0, 32'h0000_0060};
    vt[2]  = '{1'b0, 3'b001, 32'h0000_0016, 32'h0,         1'b0, 32'hFFFF_8070};
    vt[3]  = '{1'b0, 3'b101, 32'h0000_0016, 32'h0,         1'b0, 32'h0000_8070};
    vt[4]  = '{1'b0, 3'b010, 32'h0000_0014, 32'h0,         1'b0, 32'h8070_60F0};
    vt[5]  = '{1'b0, 3'b000, 32'h0000_0017, 32'h0,         1'b0, 32'hFFFF_FF80};
    vt[6]  = '{1'b0, 3'b100, 32'h0000_0016, 32'h0,         1'b0, 32'h0000_0070};
    vt[7]  = '{1'b0, 3'b001, 32'h0000_0014, 32'h0,         1'b0, 32'h0000_60F0};
    vt[8]  = '{1'b0, 3'b010, 32'h1000_0010, 32'h0,         1'b0, 32'h0BAD_F00D};
    vt[9]  = '{1'b0, 3'b010, 32'h0000_0002, 32'h0,         1'b1, 32'h0};
    vt[10] = '{1'b1, 3'b001, 32'h0000_0001, 32'h0000_FFFF, 1'b1, 32'h0};
    vt[11] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         1'b1, 32'h0};
    vt[12] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_00EE, 1'b1, 32'h0};
    vt[13] = '{1'b0, 3'b001, 32'h0000_0015, 32'h0,         1'b1, 32'h0};
    vt[14] = '{1'b0, 3'b100, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_000D};

    n_chk = 0; n_err = 0; n_wr = 0; cyc = 0;
    model_rdata = 32'h0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdat = 32'h0;
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0;
    i_funct3 = 3'b000; i_addr = 32'h0; i_wdata = 32'h0;

    repeat (2) @(posedge i_clk);
    #1;
    chk_reset_outputs("reset");

    poke(0, 32'h1357_9BDF);
    poke(4, 32'h0BAD_F00D);
    poke(5, 32'h8070_60F0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Loads, aliasing and rejected requests.
    for (int i = 0; i < 15; i++) begin
      issue(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, vt[i].err, vt[i].rd, 2, 1'b1, a1);
    end
    drain();
    chk("err_no_write_count", n_wr, 0);
    chk("err_mem0_unchanged", mem[0], 32'h1357_9BDF);

    // Sub-word read-modify-write stores.
    poke(4, 32'h1122_3344);
    poke(5, 32'h1122_3344);
    issue(1'b1, 3'b000, 32'h0000_0017, 32'h0000_00AB, 1'b0, 32'h0, 3, 1'b1, a1);
    issue(1'b1, 3'b001, 32'h0000_0012, 32'h0000_BEEF, 1'b0, 32'h0, 3, 1'b1, a1);
    drain();
    chk("sb_mem5", mem[5], 32'hAB22_3344);
    chk("sh_mem4", mem[4], 32'hBEEF_3344);
    chk("rmw_write_count", n_wr, 2);
    issue(1'b0, 3'b100, 32'h0000_0017, 32'h0, 1'b0, 32'h0000_00AB, 2, 1'b1, a1);
    drain();

    // SW then LW back-to-back.
    issue(1'b1, 3'b010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1'b1, a1);
    issue(1'b0, 3'b010, 32'h0000_0000, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b1, a2);
    drain();
    chk("b2b_accept_gap", a2 - a1, 2);
    chk("sw_mem0", mem[0], 32'hDEAD_BEEF);
    chk("sw_write_count", n_wr, 3);

    // Reset asserted while the SB write is being presented.
    poke(6, 32'hCAFE_F00D);
    issue(1'b1, 3'b000, 32'h0000_0018, 32'h0000_0055, 1'b0, 32'h0, 3, 1'b0, a1);
    chk("sb_access_no_wr", {31'h0, o_mem_wrenb}, 32'h0);
    @(posedge i_clk); #1;
    chk("merge_wrenb", {31'h0, o_mem_wrenb}, 32'h1);
    chk("merge_wdata", o_mem_wdata, 32'hCAFE_F055);
    chk("merge_addr", {22'h0, o_mem_addr}, 32'h6);
    wr_snap = n_wr;
    i_rst_n = 1'b0;
    model_rdata = 32'h0;
    #1;
    chk_reset_outputs("midrmw");
    repeat (2) @(posedge i_clk);
    #1;
    chk("midrmw_mem6", mem[6], 32'hCAFE_F00D);
    chk("midrmw_write_count", n_wr, wr_snap);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("post_reset_ready", {31'h0, o_req_ready}, 32'h1);
    issue(1'b0, 3'b010, 32'h0000_0018, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 1'b1, a1);
    drain();
    repeat (3) @(posedge i_clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store requester that drives the word-addressed, async-read/sync-write data memory on behalf of the RV32I execute stage.
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses:
  - lane extraction and sign/zero extension for loads;
  - two-cycle read-modify-write for sub-word stores.
- Raises a one-cycle response with an error flag for misaligned or illegal requests; the pipeline stalls on o_req_ready.

Parameters:
- ADDR_W, 10, memory word-address width (memory depth 2^ADDR_W words; byte address bits [ADDR_W+1:2] used, upper bits ignored and aliased).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted this cycle when valid&&ready.
- i_req_we  in  1  1=store, 0=load.
- i_funct3  in  3  RV32I funct3 of the load/store.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data (rs2).
- o_mem_addr  out  ADDR_W  word address to memory.
- o_mem_wdata  out  32  write word to memory.
- o_mem_wrenb  out  1  memory write enable.
- i_mem_rdata  in  32  memory read word (combinational from o_mem_addr).
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_err  out  1  misaligned/illegal, qualified by o_rsp_valid.
- o_rdata  out  32  load result, qualified by o_rsp_valid&&!i_req_we of that request.

Behaviour:
- States: IDLE, ACCESS, MERGE_WR, ERR. o_req_ready = (state==IDLE), combinational.
- Accept (IDLE, valid): latch we, funct3, addr[1:0], word address, wdata into command registers.
  - Legal request -> ACCESS.
  - Illegal/misaligned -> ERR; memory is never written.
- Legal funct3: loads 000,001,010,100,101; stores 000,001,010. All others are illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- ACCESS:
  - o_mem_addr = latched word address.
  - Load: extract the lane selected by addr[1:0] (little-endian: byte k = bits 8k+7:8k, halfword at offset 2 = bits 31:16). Sign-extend for LB/LH, zero-extend for LBU/LHU, pass-through for LW. Register the result into o_rdata and pulse o_rsp_valid next cycle. -> IDLE.
  - SW: o_mem_wrenb=1, o_mem_wdata=wdata; pulse o_rsp_valid next cycle. -> IDLE.
  - SB/SH: capture i_mem_rdata into a merge register. -> MERGE_WR.
- MERGE_WR:
  - o_mem_wrenb=1.
  - o_mem_wdata = merge word with the selected byte replaced by wdata[7:0] (SB) or the selected halfword replaced by wdata[15:0] (SH).
  - Pulse o_rsp_valid next cycle. -> IDLE.
- ERR: next cycle o_rsp_valid=1, o_rsp_err=1, o_rdata=0. -> IDLE.
- Latency, accept edge to o_rsp_valid high: loads/SW 2 cycles; SB/SH 3 cycles; errors 2 cycles.
- Back-to-back: a new request is accepted in the same cycle o_rsp_valid pulses, since state is already IDLE.
- o_mem_wrenb is high only in ACCESS (SW) or MERGE_WR, for exactly one cycle per store. It is decoded from registered state only.
- Outside ACCESS/MERGE_WR, o_mem_addr holds its last value and o_mem_wrenb=0.
- i_req_* are ignored when not ready; the requester holds them stable until accepted.
- Reset (any time, including mid-RMW): state=IDLE, command/merge registers=0, o_rsp_valid=0, o_rsp_err=0, o_rdata=0, o_mem_addr=0, o_mem_wdata=0, o_mem_wrenb=0. An in-flight store is aborted with no write. o_req_ready=1 during reset.
- o_rdata holds its value between responses; it is unchanged by store responses.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101), state encoding, and an is_misaligned helper function.
- One combinational sub-module, lsu_lane_align:
  - load extract/extend path (rdata, off, funct3 -> result);
  - store merge path (old word, wdata, off, funct3 -> merged word).

Test Plan:
- Memory word 5 = 0x8070_60F0. LB addr 0x14 -> 0xFFFF_FFF0; LBU 0x15 -> 0x0000_0060; LH 0x16 -> 0xFFFF_8070; LHU 0x16 -> 0x0000_8070; each rsp 2 cycles after accept, err=0.
- SB wdata 0x0000_00AB to addr 0x17 over word 0x1122_3344 -> one wrenb pulse in MERGE_WR writing 0xAB22_3344; rsp at cycle 3. SH 0xBEEF to 0x12 over 0x1122_3344 -> 0xBEEF_3344.
- SW 0xDEAD_BEEF to 0x0 then LW 0x0 back-to-back (second accepted on first's rsp cycle) -> rdata 0xDEAD_BEEF; wrenb high exactly one cycle.
- LW addr 0x2, SH addr 0x1, funct3=011 load -> rsp_err=1, rdata=0, wrenb never asserted, memory unchanged.
- Assert i_rst_n=0 during MERGE_WR of SB -> wrenb stays 0, target word unchanged, all outputs 0, ready=1 after release.
- Address 0x1000_0010 load -> aliases to word 4 (upper bits ignored), err=0.
